// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester (cpu/dbg) arbiter for a single memory bank port with round-robin fairness, a bounded debug lock and registered read return.
// Ports: clk, rst_n (async active-low); cpu_*/dbg_* request, we, addr, wdata inputs; dbg_lock;
//        cpu_gnt/dbg_gnt (combinational), cpu_rvalid/dbg_rvalid + cpu_rdata/dbg_rdata (registered);
//        mem_address, mem_data_in, mem_write_enable to the bank, mem_data_out from the bank.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int LOCK_MAX   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  input  logic                  dbg_lock,
  output logic                  cpu_gnt,
  output logic                  dbg_gnt,
  output logic                  cpu_rvalid,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_write_enable,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);
  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LMAX = CW'(LOCK_MAX);
  typedef enum logic [1:0] {OPEN, LOCKED, COOLDOWN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d, lock_cnt_inc;
  logic last_dbg_q, last_dbg_d;
  logic cpu_rvalid_q, cpu_rvalid_d, dbg_rvalid_q, dbg_rvalid_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;
  logic held, cool;
  always_comb begin
    held = (state_q == LOCKED) && dbg_lock;
    cool = state_q == COOLDOWN;
    // Grants are gated by rst_n so an asserted reset kills an in-flight access immediately.
    cpu_gnt = rst_n && cpu_req && !held && (cool || !dbg_req || last_dbg_q);
    dbg_gnt = rst_n && dbg_req && !cool && (held || !cpu_req || !last_dbg_q);
    mem_address = cpu_gnt ? cpu_addr : dbg_gnt ? dbg_addr : '0;
    mem_data_in = cpu_gnt ? cpu_wdata : dbg_gnt ? dbg_wdata : '0;
    mem_write_enable = (cpu_gnt && cpu_we) || (dbg_gnt && dbg_we);
    last_dbg_d = cpu_gnt ? 1'b0 : dbg_gnt ? 1'b1 : last_dbg_q;
    cpu_rvalid_d = cpu_gnt && !cpu_we;
    dbg_rvalid_d = dbg_gnt && !dbg_we;
    cpu_rdata_d = cpu_rvalid_d ? mem_data_out : cpu_rdata_q;
    dbg_rdata_d = dbg_rvalid_d ? mem_data_out : dbg_rdata_q;
    lock_cnt_inc = lock_cnt_q + 1'b1;
    state_d = OPEN;
    lock_cnt_d = '0;
    // The counter counts lock grants including the one that opened the lock, so the
    // LOCK_MAX-th consecutive locked cycle is the last before the forced release.
    if (held) begin
      lock_cnt_d = lock_cnt_inc;
      state_d = (lock_cnt_inc == LMAX) ? COOLDOWN : LOCKED;
    end else if (!cool && dbg_gnt && dbg_lock) begin
      lock_cnt_d = CW'(1);
      state_d = (LMAX == CW'(1)) ? COOLDOWN : LOCKED;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OPEN;
      lock_cnt_q <= '0;
      last_dbg_q <= 1'b1;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      lock_cnt_q <= lock_cnt_d;
      last_dbg_q <= last_dbg_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end
  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a small behavioural memory bank.
module tb_mem_port_arbiter;
  typedef struct {logic dbg; logic we; logic [4:0] addr; logic [7:0] data;} gnt_t;
  logic clk = 1'b0, rst_n;
  logic cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
  logic [4:0] cpu_addr, dbg_addr, mem_address;
  logic [7:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata, mem_data_in, mem_data_out;
  logic cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_write_enable;
  logic [7:0] mem [0:31] = '{3: 8'h5A, default: 8'h00};
  gnt_t gq[$];
  logic [7:0] rq_cpu[$], rq_dbg[$];
  gnt_t e;
  int checks = 0, errors = 0;

  mem_port_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .LOCK_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .cpu_gnt(cpu_gnt), .dbg_gnt(dbg_gnt),
    .cpu_rvalid(cpu_rvalid), .dbg_rvalid(dbg_rvalid), .cpu_rdata(cpu_rdata), .dbg_rdata(dbg_rdata),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_write_enable(mem_write_enable),
    .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;
  assign mem_data_out = mem[mem_address];
  always @(posedge clk) if (mem_write_enable) mem[mem_address] <= mem_data_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got an output with nothing expected", name);
  endtask

  task automatic exp_gnt(input logic dbg, input logic we, input logic [4:0] a, input logic [7:0] d);
    gq.push_back('{dbg, we, a, d});
  endtask

  task automatic drv(input logic cr, input logic cw, input logic [4:0] ca, input logic [7:0] cd,
                     input logic dr, input logic dw, input logic [4:0] da, input logic [7:0] dd,
                     input logic lk);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd; dbg_lock = lk;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drv(0, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00, 0);
  endtask

  always @(negedge clk) begin
    if (cpu_gnt && dbg_gnt) unexpected("double_grant");
    if (cpu_gnt || dbg_gnt) begin
      if (gq.size() == 0) unexpected("grant");
      else begin
        e = gq.pop_front();
        check("gnt_is_dbg", 32'(dbg_gnt), 32'(e.dbg));
        check("gnt_we", 32'(mem_write_enable), 32'(e.we));
        check("gnt_addr", 32'(mem_address), 32'(e.addr));
        check("gnt_wdata", 32'(mem_data_in), 32'(e.data));
      end
    end else check("idle_bus", {19'd0, mem_write_enable, mem_address, mem_data_in}, 32'd0);
    if (cpu_rvalid) begin
      if (rq_cpu.size() == 0) unexpected("cpu_rvalid");
      else check("cpu_rdata", 32'(cpu_rdata), 32'(rq_cpu.pop_front()));
    end
    if (dbg_rvalid) begin
      if (rq_dbg.size() == 0) unexpected("dbg_rvalid");
      else check("dbg_rdata", 32'(dbg_rdata), 32'(rq_dbg.pop_front()));
    end
  end

  initial begin
    rst_n = 1'b0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 5'd7; cpu_wdata = 8'h33;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_lock = 0;
    @(posedge clk);
    #1;
    check("rst_cpu_gnt", 32'(cpu_gnt), 0);
    check("rst_we", 32'(mem_write_enable), 0);
    check("rst_rvalid", {30'd0, cpu_rvalid, dbg_rvalid}, 0);
    check("rst_rdata", {16'd0, cpu_rdata, dbg_rdata}, 0);
    idle();
    rst_n = 1'b1;
    repeat (4) begin
      exp_gnt(0, 1, 5'd1, 8'h11);
      exp_gnt(1, 1, 5'd2, 8'h22);
    end
    repeat (4) drv(1, 1, 5'd1, 8'h11, 1, 1, 5'd2, 8'h22, 0);
    repeat (4) void'(gq.pop_back());
    exp_gnt(0, 0, 5'd3, 8'h00);
    rq_cpu.push_back(8'h5A);
    drv(1, 0, 5'd3, 8'h00, 0, 0, 5'd0, 8'h00, 0);
    check("rd_latency_rvalid", 32'(cpu_rvalid), 1);
    check("rd_latency_rdata", 32'(cpu_rdata), 32'h5A);
    idle();
    check("rvalid_one_cycle", 32'(cpu_rvalid), 0);
    check("rdata_hold", 32'(cpu_rdata), 32'h5A);
    exp_gnt(1, 1, 5'd31, 8'hF0);
    drv(0, 0, 5'd0, 8'h00, 1, 1, 5'd31, 8'hF0, 0);
    check("wr_no_rvalid", 32'(dbg_rvalid), 0);
    idle();
    exp_gnt(1, 0, 5'd31, 8'h00);
    rq_dbg.push_back(8'hF0);
    drv(0, 0, 5'd0, 8'h00, 1, 0, 5'd31, 8'h00, 0);
    idle();
    exp_gnt(1, 1, 5'd4, 8'h44);
    drv(0, 0, 5'd0, 8'h00, 1, 1, 5'd4, 8'h44, 1);
    exp_gnt(1, 1, 5'd5, 8'h55);
    drv(1, 1, 5'd7, 8'h77, 1, 1, 5'd5, 8'h55, 1);
    exp_gnt(1, 1, 5'd6, 8'h66);
    drv(1, 1, 5'd7, 8'h77, 1, 1, 5'd6, 8'h66, 1);
    exp_gnt(0, 1, 5'd7, 8'h77);
    drv(1, 1, 5'd7, 8'h77, 1, 1, 5'd6, 8'h66, 0);
    exp_gnt(1, 1, 5'd6, 8'h66);
    drv(0, 0, 5'd0, 8'h00, 1, 1, 5'd6, 8'h66, 0);
    exp_gnt(1, 1, 5'd8, 8'h88);
    drv(0, 0, 5'd0, 8'h00, 1, 1, 5'd8, 8'h88, 1);
    repeat (3) begin
      exp_gnt(1, 1, 5'd8, 8'h88);
      drv(1, 1, 5'd9, 8'h99, 1, 1, 5'd8, 8'h88, 1);
    end
    exp_gnt(0, 1, 5'd9, 8'h99);
    drv(1, 1, 5'd9, 8'h99, 1, 1, 5'd8, 8'h88, 1);
    exp_gnt(1, 1, 5'd8, 8'h88);
    drv(0, 0, 5'd0, 8'h00, 1, 1, 5'd8, 8'h88, 0);
    exp_gnt(0, 0, 5'd3, 8'h00);
    drv(1, 0, 5'd3, 8'h00, 0, 0, 5'd0, 8'h00, 0);
    cpu_we = 1; cpu_addr = 5'd10; cpu_wdata = 8'hAB;
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_gnt", 32'(cpu_gnt), 0);
    check("async_rst_rvalid", 32'(cpu_rvalid), 0);
    check("async_rst_we", 32'(mem_write_enable), 0);
    check("async_rst_rdata", 32'(cpu_rdata), 0);
    idle();
    rst_n = 1'b1;
    exp_gnt(0, 0, 5'd3, 8'h00);
    rq_cpu.push_back(8'h5A);
    drv(1, 0, 5'd3, 8'h00, 1, 0, 5'd31, 8'h00, 0);
    exp_gnt(1, 0, 5'd31, 8'h00);
    rq_dbg.push_back(8'hF0);
    drv(0, 0, 5'd0, 8'h00, 1, 0, 5'd31, 8'h00, 0);
    idle();
    idle();
    check("unanswered_grants", gq.size(), 0);
    check("unanswered_cpu_reads", rq_cpu.size(), 0);
    check("unanswered_dbg_reads", rq_dbg.size(), 0);
    check("mem_10_untouched", 32'(mem[10]), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
